// File: rtl/rr_arb8_pkg.sv
// rr_arb8_pkg: shared definitions for the 8-way round-robin arbiter.
//   ARB_N / ARB_IDX_W : requester count and index width
//   arb_state_e       : arbiter FSM state encoding
//   rr_pick()         : rotating-priority first-one finder
package rr_arb8_pkg;

   localparam int ARB_N     = 8;
   localparam int ARB_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Returns the first set request scanning ptr, ptr+1, ... mod 8.
   // Scanning from the far end down lets the closest hit overwrite the rest.
   // Result is only meaningful when req != 0.
   function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_N-1:0]     req,
                                                   input logic [ARB_IDX_W-1:0] ptr);
      logic [ARB_IDX_W-1:0] win;
      logic [ARB_IDX_W-1:0] k;
      win = ptr;
      for (int i = ARB_N - 1; i >= 0; i--) begin
         k = ptr + ARB_IDX_W'(i);
         if (req[k]) win = k;
      end
      return win;
   endfunction

endpackage

// File: rtl/rr_arb8_dc3_8.sv
// dc3_8: 3-to-8 one-hot decoder with enable.
//   a   : select index
//   ena : when low, all outputs are zero
//   d   : one-hot output, d[a] set when ena=1
module dc3_8 (
   input  logic [2:0] a,
   input  logic       ena,
   output logic [7:0] d
);

   always_comb begin
      d = '0;
      if (ena) d[a] = 1'b1;
   end

endmodule

// File: rtl/rr_arb8.sv
// rr_arb8: round-robin arbiter sharing one resource among 8 requesters.
// A winner is picked from IDLE with rotating priority, holds the grant until
// done, request drop, ena low or MAX_HOLD cycles, then priority rotates past it.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   ena      : arbiter enable; low releases any grant
//   req      : request vector, bit i = requester i
//   done     : release strobe from the current owner
//   gnt      : one-hot grant
//   gnt_idx  : index of the current owner (valid with gnt_vld)
//   gnt_vld  : a grant is active
//   timeout  : one-cycle pulse, grant revoked by MAX_HOLD
//
// state    | meaning
// ST_IDLE  | no owner; arbitrates when ena=1 and req!=0
// ST_GRANT | owner gnt_idx holds the resource, hold counter running
module rr_arb8
   import rr_arb8_pkg::*;
#(
   parameter  int MAX_HOLD = 16,
   localparam int HOLD_W   = $clog2(MAX_HOLD)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic [ARB_N-1:0]     req,
   input  logic                 done,
   output logic [ARB_N-1:0]     gnt,
   output logic [ARB_IDX_W-1:0] gnt_idx,
   output logic                 gnt_vld,
   output logic                 timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_e           state_q;
   logic [ARB_IDX_W-1:0] ptr_q;
   logic [ARB_IDX_W-1:0] idx_q;
   logic [HOLD_W-1:0]    hold_q;
   logic                 timeout_q;
   logic [ARB_IDX_W-1:0] win_d;

   assign win_d = rr_pick(req, ptr_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         idx_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ena && (req != '0)) begin
                  state_q <= ST_GRANT;
                  idx_q   <= win_d;
                  hold_q  <= '0;
               end
            end
            ST_GRANT: begin
               hold_q <= hold_q + HOLD_W'(1);
               // Release priority: enable loss keeps ptr so the same owner
               // can win again; done beats a coincident timeout.
               if (!ena) begin
                  state_q <= ST_IDLE;
               end else if (done || !req[idx_q]) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= idx_q + ARB_IDX_W'(1);
               end else if (hold_q == HOLD_LAST) begin
                  state_q   <= ST_IDLE;
                  ptr_q     <= idx_q + ARB_IDX_W'(1);
                  timeout_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign gnt_vld = (state_q == ST_GRANT);
   assign gnt_idx = idx_q;
   assign timeout = timeout_q;

   dc3_8 u_dec (
      .a   (idx_q),
      .ena (gnt_vld),
      .d   (gnt)
   );

endmodule
